// File: rtl/cache_burst_responder.sv
// Memory-side responder for the cache: fetches a 4-word line critical-word-first and
// streams it behind a one-cycle fill strobe, or performs a single masked word write.
module cache_burst_responder #(
    parameter int ADDR_WIDTH = 26,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           req_addr,
    input  logic                  req,
    input  logic                  req_rw,
    input  logic [15:0]           req_wdata,
    input  logic [1:0]            req_be,
    output logic                  fill,
    output logic [15:0]           rdata,
    output logic                  wack,
    output logic                  error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic [1:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata,
    output logic [2:0]            fsm_state
);

    // Memory handshake: mem_req is held until the cycle mem_ack is seen high; the
    // access completes on that cycle and mem_ack outside an active request is ignored.

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_FETCH  = 3'd1;
    localparam logic [2:0] RD_STREAM = 3'd2;
    localparam logic [2:0] WR_ACC    = 3'd3;
    localparam logic [2:0] WR_DONE   = 3'd4;
    localparam logic [2:0] WAIT_REL  = 3'd5;

    localparam int WD_W = $clog2(MAX_WAIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

    logic [2:0]            state;
    logic                  armed;
    logic [ADDR_WIDTH-4:0] line;
    logic [1:0]            k;
    logic [1:0]            idx;
    logic [1:0]            j;
    logic [15:0]           line_buf [4];
    logic [WD_W-1:0]       wd_cnt;

    logic [1:0] fetch_off;
    logic [1:0] stream_next;
    logic       wd_expire;

    // Offsets are 2 bits wide so the word index wraps inside the line by construction.
    assign fetch_off   = k + idx;
    assign stream_next = k + j + 2'd1;
    assign wd_expire   = mem_req && !mem_ack && (wd_cnt == WD_LAST);
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (!reset && state == RD_FETCH && mem_req && mem_ack) begin
            line_buf[fetch_off] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b1;
            fill      <= 1'b0;
            wack      <= 1'b0;
            error     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            line      <= '0;
            k         <= '0;
            idx       <= '0;
            j         <= '0;
            wd_cnt    <= '0;
        end else begin
            fill <= 1'b0;
            wack <= 1'b0;
            if (!req) begin
                armed <= 1'b1;
            end
            if (mem_req && !mem_ack) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (req && armed) begin
                        armed    <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= {req_addr[ADDR_WIDTH-1:1], 1'b0};
                        if (req_rw) begin
                            line    <= req_addr[ADDR_WIDTH-1:3];
                            k       <= req_addr[2:1];
                            idx     <= 2'd0;
                            mem_we  <= 1'b0;
                            state   <= RD_FETCH;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                            mem_be    <= req_be;
                            state     <= WR_ACC;
                        end
                    end
                end

                RD_FETCH: begin
                    if (wd_expire) begin
                        error   <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= WAIT_REL;
                    end else if (mem_req) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            if (idx == 2'd3) begin
                                // Critical word was the first one fetched, so it is already buffered.
                                fill  <= 1'b1;
                                rdata <= line_buf[k];
                                j     <= 2'd0;
                                state <= RD_STREAM;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= {line, fetch_off, 1'b0};
                    end
                end

                RD_STREAM: begin
                    if (j == 2'd3) begin
                        state <= WAIT_REL;
                    end else begin
                        j     <= j + 2'd1;
                        rdata <= line_buf[stream_next];
                    end
                end

                WR_ACC: begin
                    if (wd_expire) begin
                        error   <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= WAIT_REL;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        wack    <= 1'b1;
                        state   <= WR_DONE;
                    end
                end

                WR_DONE: begin
                    state <= WAIT_REL;
                end

                WAIT_REL: begin
                    if (!req) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_burst_responder.sv
// Bench for cache_burst_responder: latency-programmable memory model, access and
// read-data scoreboards, a vector table plus hand sequences for reset and watchdog.
module tb_cache_burst_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_addr;
    logic        req;
    logic        req_rw;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        fill;
    logic [15:0] rdata;
    logic        wack;
    logic        error;
    logic        mem_req;
    logic        mem_we;
    logic [25:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [2:0]  fsm_state;

    cache_burst_responder #(.ADDR_WIDTH(26), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .req_addr(req_addr), .req(req), .req_rw(req_rw),
        .req_wdata(req_wdata), .req_be(req_be), .fill(fill), .rdata(rdata), .wack(wack),
        .error(error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 0;
    bit ack_en = 1'b1;
    int fill_cnt = 0;
    int wack_cnt = 0;
    int rd_acks = 0;
    int last4 = -10;
    int stream_left = 0;

    logic [15:0] exp_q[$];
    logic [26:0] exp_acc_q[$];
    logic [17:0] exp_wr_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          lat;
        int          hold;
        int          exp_fills;
        int          exp_wacks;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [15:0] model_word(input logic [25:0] a);
        return a[15:0] ^ 16'h5A3C ^ {6'h00, a[25:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: decides mem_ack for the current cycle just after each rising edge.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            if (reset || !ack_en || !mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 16'hDEAD : model_word(mem_addr);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Monitor and scoreboards, sampled mid-cycle.
    initial begin
        logic [26:0] e;
        logic [17:0] w;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                stream_left = 0;
                rd_acks     = 0;
            end else begin
                if (mem_req && mem_ack) begin
                    if (exp_acc_q.size() == 0) begin
                        check("acc_unexpected", {6'h0, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_acc_q.pop_front();
                        check("mem_we", {31'h0, mem_we}, {31'h0, e[26]});
                        check("mem_addr", {6'h0, mem_addr}, {6'h0, e[25:0]});
                    end
                    if (mem_we) begin
                        if (exp_wr_q.size() == 0) begin
                            check("wr_unexpected", {14'h0, mem_be, mem_wdata}, 32'hFFFF_FFFF);
                        end else begin
                            w = exp_wr_q.pop_front();
                            check("mem_be_wdata", {14'h0, mem_be, mem_wdata}, {14'h0, w});
                        end
                    end else begin
                        rd_acks++;
                        if (rd_acks == 4) last4 = cyc;
                    end
                end
                if (fill) begin
                    fill_cnt++;
                    check("fill_after_4th_ack", rd_acks, 4);
                    check("fill_latency", cyc, last4 + 1);
                    check("fill_in_stream", stream_left, 0);
                    rd_acks     = 0;
                    stream_left = 4;
                end
                if (stream_left > 0) begin
                    if (exp_q.size() == 0) begin
                        check("rdata_unexpected", {16'h0, rdata}, 32'hFFFF_FFFF);
                    end else begin
                        d = exp_q.pop_front();
                        check("rdata", {16'h0, rdata}, {16'h0, d});
                    end
                    stream_left--;
                end
                if (wack) wack_cnt++;
            end
        end
    end

    task automatic run_txn(input logic [31:0] addr, input logic rw, input logic [15:0] wd,
                           input logic [1:0] be, input int lat_i, input int hold,
                           input int exp_fills, input int exp_wacks);
        int f0, w0, n;
        logic err0;
        logic [25:0] a;
        lat  = lat_i;
        f0   = fill_cnt;
        w0   = wack_cnt;
        err0 = error;
        if (rw) begin
            for (int i = 0; i < 4; i++) begin
                a = {addr[25:3], 2'(addr[2:1] + 2'(i)), 1'b0};
                exp_acc_q.push_back({1'b0, a});
                exp_q.push_back(model_word(a));
            end
        end else begin
            exp_acc_q.push_back({1'b1, addr[25:1], 1'b0});
            exp_wr_q.push_back({be, wd});
        end
        @(negedge clk);
        req_addr  = addr;
        req_rw    = rw;
        req_wdata = wd;
        req_be    = be;
        req       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fill && !wack && !(error && !err0) && n < 400);
        if (n >= 400) check("done_timeout", n, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("no_rerequest_while_held", {31'h0, mem_req}, 32'h0);
        end
        req = 1'b0;
        repeat (6) @(negedge clk);
        check("fill_count", fill_cnt - f0, exp_fills);
        check("wack_count", wack_cnt - w0, exp_wacks);
        check("acc_q_empty", exp_acc_q.size(), 0);
        check("rd_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, hi, f0;
        vecs[0] = '{32'h0000_1004, 1'b1, 16'h0000, 2'b00, 2, 0, 1, 0};
        vecs[1] = '{32'h0000_0008, 1'b1, 16'h0000, 2'b00, 0, 3, 1, 0};
        vecs[2] = '{32'h0000_2002, 1'b0, 16'hBEEF, 2'b10, 1, 0, 0, 1};
        vecs[3] = '{32'h03FF_FFFE, 1'b1, 16'h0000, 2'b00, 1, 0, 1, 0};
        vecs[4] = '{32'h0000_0010, 1'b0, 16'h1234, 2'b00, 0, 2, 0, 1};
        vecs[5] = '{32'h0000_100A, 1'b1, 16'h0000, 2'b00, 3, 0, 1, 0};
        vecs[6] = '{32'hFC00_0006, 1'b1, 16'h0000, 2'b00, 0, 0, 1, 0};

        reset = 1'b1; req = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        check("rst_state", {29'h0, fsm_state}, 32'h0);
        check("rst_strobes", {27'h0, fill, wack, error, mem_req, mem_we}, 32'h0);
        check("rst_rdata", {16'h0, rdata}, 32'h0);
        check("rst_mem_data", {mem_addr, mem_be, 4'h0}, 32'h0);
        check("rst_wdata", {16'h0, mem_wdata}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].addr, vecs[i].rw, vecs[i].wdata, vecs[i].be, vecs[i].lat,
                    vecs[i].hold, vecs[i].exp_fills, vecs[i].exp_wacks);
        end
        check("no_error_yet", {31'h0, error}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            logic rw;
            rw = 1'($urandom_range(0, 1));
            run_txn($urandom_range(0, 32'h03FF_FFFF), rw, 16'($urandom), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 2), rw ? 1 : 0, rw ? 0 : 1);
        end

        // Reset in the middle of a line fetch, after two words have arrived.
        lat = 3;
        for (int i = 0; i < 4; i++) begin
            exp_acc_q.push_back({1'b0, 26'h3000 + 26'(2 * i)});
            exp_q.push_back(16'h0);
        end
        @(negedge clk);
        req_addr = 32'h0000_3000; req_rw = 1'b1; req = 1'b1;
        n = 0;
        while (rd_acks < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_wait", {31'h0, (n >= 100)}, 32'h0);
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        check("rst_mid_strobes", {29'h0, fill, mem_req, wack}, 32'h0);
        check("rst_mid_state", {29'h0, fsm_state}, 32'h0);
        exp_acc_q.delete();
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        run_txn(32'h0000_3006, 1'b1, 16'h0, 2'b00, 1, 0, 1, 0);

        // Watchdog: memory never answers.
        ack_en = 1'b0;
        f0 = fill_cnt;
        @(negedge clk);
        req_addr = 32'h0000_0040; req_rw = 1'b1; req = 1'b1;
        hi = 0;
        n  = 0;
        while (!error && n < 50) begin
            @(negedge clk);
            n++;
            if (mem_req) hi++;
        end
        check("wd_mem_req_cycles", hi, 8);
        check("wd_error", {31'h0, error}, 32'h1);
        check("wd_mem_req_dropped", {31'h0, mem_req}, 32'h0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("wd_no_fill", fill_cnt - f0, 0);
        ack_en = 1'b1;
        run_txn(32'h0000_0042, 1'b1, 16'h0, 2'b00, 0, 0, 1, 0);
        run_txn(32'h0000_0044, 1'b0, 16'hCAFE, 2'b01, 2, 0, 0, 1);
        check("error_sticky", {31'h0, error}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
